mem_bridge: RTL and testbench
=============================

# mem_bridge

Single-port memory bridge that sits directly downstream of the CPU core's memory interface and serves its instruction-fetch and load/store requests from an on-chip word-organised SRAM. It checks each request, adds configurable wait states, performs byte-lane selection and read-modify-write for byte stores, and returns data with a one-cycle ready/error response. A side-band init port preloads program images before the core runs.

## Interface
- `ADDR_WIDTH`, default 10: word-address bits; capacity is 4·2^ADDR_WIDTH bytes.
- `WAIT_STATES`, default 1: extra idle cycles inserted before every SRAM access (0–15).
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  reset: synchronous, active-low.
- `cpu_addr`  in  32  byte address of the request.
- `cpu_wdata`  in  32  store data; a byte store uses bits [7:0].
- `cpu_read`  in  1  read request level.
- `cpu_write`  in  1  write request level.
- `cpu_byte`  in  1  byte access when 1, word access when 0.
- `cpu_rdata`  out  32  read data, held until the next response.
- `cpu_ready`  out  1  one-cycle response pulse.
- `cpu_error`  out  1  error flag, valid only while `cpu_ready` is 1.
- `init_we`  in  1  preload write strobe.
- `init_addr`  in  ADDR_WIDTH  preload word address.
- `init_data`  in  32  preload word.

## Operation
- States: IDLE, WAIT, ACCESS, MERGE, RESP, ERR.
- In IDLE, `init_we`=1 writes `init_data` to word `init_addr`. No CPU request is sampled that cycle. `init_we` is ignored in every other state.
- In IDLE, with `init_we`=0 and `cpu_read`|`cpu_write` high, the request is latched (addr, wdata, byte, dir).
  - If there is an error, go to ERR.
  - Otherwise, if `WAIT_STATES`>0, go to WAIT; if not, go to ACCESS.
- Error conditions, checked at sampling:
  - `cpu_read` and `cpu_write` are both high;
  - a word access with `cpu_addr[1:0]`≠0;
  - `cpu_addr` ≥ 4·2^ADDR_WIDTH.
- ERR: assert `cpu_ready`=1 and `cpu_error`=1 for one cycle. `cpu_rdata` is unchanged and the SRAM is untouched. Then go to IDLE.
- WAIT: a counter loads `WAIT_STATES`−1 and decrements. When it reaches 0, go to ACCESS.
- ACCESS: present the word address `addr[ADDR_WIDTH+1:2]` to the SRAM.
  - Word write: write all four lanes, then go to RESP.
  - Read: go to RESP.
  - Byte write: issue a read and go to MERGE.
- MERGE: replace lane k=`addr[1:0]` (bits 8k+7:8k) with `wdata[7:0]` and write the word back. Go to RESP.
- RESP: assert `cpu_ready`=1 and `cpu_error`=0 for one cycle.
  - Word read: `cpu_rdata` = the stored word.
  - Byte read: `cpu_rdata` = lane k, zero-extended.
  - Write: `cpu_rdata` is unchanged.
  - Then go to IDLE.
- Request inputs are don't-care outside IDLE. There is no queueing. A request still held high in IDLE after its response is treated as a new request.
- Lane order is little-endian within the stored word; endian swapping stays in the core.

## Timing
- Reset (`rst`=0 at an edge): state goes to IDLE; `cpu_ready`=0, `cpu_error`=0, `cpu_rdata`=0, wait counter cleared. Reset mid-operation abandons the access; a pending MERGE write is not performed. SRAM contents are not cleared.
- The sampling edge is E0. `cpu_ready` is high in the cycle after these edges:
  - Read or word write: edge E0+1+WAIT_STATES+1 (default: the third cycle after E0).
  - Byte write: one cycle later than a read.
  - Error: the cycle after E0.
- SRAM read latency is 1 cycle, with registered output.
- Back-to-back: the earliest next sampling is in the IDLE cycle immediately after RESP.

## Structure
- Shared package `mem_bridge_pkg`: state enum, `MAX_WAIT_STATES`=15, lane-extract and lane-merge functions.
- Sub-module `sram_1rw`: single-port synchronous RAM with registered read data, a 4-bit byte-enable write, and parameter `ADDR_WIDTH`. The bridge muxes the init and CPU paths onto its single port.

## Test plan
- Preload: init word 0 = 0x11223344. A word read at 0x0 returns `cpu_rdata`=0x11223344, `cpu_error`=0, with `cpu_ready` exactly 3 cycles after sampling (WAIT_STATES=1).
- Byte access on that word:
  - Byte read at 0x2 returns 0x00000022.
  - Byte write of 0xAB to 0x1, then word read at 0x0, returns 0x1122AB44. The byte-write response is 4 cycles after sampling.
- Errors, each giving `cpu_ready`=`cpu_error`=1 one cycle after sampling, with no SRAM change:
  - Word read at 0x6;
  - Read at 0x1000 (ADDR_WIDTH=10);
  - `cpu_read` and `cpu_write` both high.
- WAIT_STATES=0 vs 5: word read latency is 2 vs 7 cycles. `init_we` asserted during WAIT is ignored: the target word is unchanged.
- Collision in IDLE: `init_we` and `cpu_read` in the same cycle. The init write lands, and the read is sampled the next cycle and returns the new data.
- Reset mid-operation: assert `rst`=0 in the MERGE cycle of a byte write. Outputs go to 0, the state goes to IDLE, and a later read shows the original word unmodified.

Source files
------------

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared state encoding, limits and byte-lane helpers for the memory bridge
package mem_bridge_pkg;
    typedef enum logic [2:0] {IDLE, WAIT, ACCESS, MERGE, RESP, ERR} state_t;
    localparam int MAX_WAIT_STATES = 15;
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] k);
        return {24'h0, word[8*k +: 8]};
    endfunction
    function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] k, input logic [7:0] b);
        logic [31:0] r;
        r = word;
        r[8*k +: 8] = b;
        return r;
    endfunction
endpackage

// File: rtl/sram_1rw.sv
// sram_1rw: single-port word RAM with byte-enable writes and registered read data
module sram_1rw #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [2**ADDR_WIDTH];
    // enabled cycle: write selected lanes, register the old word onto rdata
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++)
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            rdata <= mem[addr];
        end
    end
endmodule

// File: rtl/mem_bridge.sv
// mem_bridge: CPU request checker, wait-state sequencer and byte read-modify-write front end for an on-chip SRAM
module mem_bridge import mem_bridge_pkg::*; #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           cpu_addr,
    input  logic [31:0]           cpu_wdata,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic                  cpu_byte,
    output logic [31:0]           cpu_rdata,
    output logic                  cpu_ready,
    output logic                  cpu_error,
    input  logic                  init_we,
    input  logic [ADDR_WIDTH-1:0] init_addr,
    input  logic [31:0]           init_data
);
    localparam int WS = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [3:0] WAIT_LOAD = (WS > 0) ? 4'(WS - 1) : 4'd0;

    state_t                state, state_next;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q, rdata_q, resp_data, ram_rdata, ram_wdata;
    logic                  byte_q, write_q, req, bad, ram_en;
    logic [3:0]            wait_cnt, ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;

    assign req = (state == IDLE) && !init_we && (cpu_read || cpu_write);
    assign bad = (cpu_read && cpu_write) || (!cpu_byte && cpu_addr[1:0] != 2'd0) ||
                 ((cpu_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // state register; reset abandons any access in flight
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // next-state: byte stores take the extra MERGE cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = bad ? ERR : (WS > 0 ? WAIT : ACCESS);
            WAIT:    if (wait_cnt == 4'd0) state_next = ACCESS;
            ACCESS:  state_next = (write_q && byte_q) ? MERGE : RESP;
            MERGE:   state_next = RESP;
            default: state_next = IDLE;
        endcase
    end

    // request capture, wait countdown and held read data
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
            rdata_q  <= 32'd0;
        end else begin
            if (req) begin
                addr_q   <= cpu_addr[ADDR_WIDTH+1:0];
                wdata_q  <= cpu_wdata;
                byte_q   <= cpu_byte;
                write_q  <= cpu_write;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == RESP && !write_q) rdata_q <= resp_data;
        end
    end

    // single RAM port: init owns it in IDLE, the CPU path in ACCESS/MERGE; gated by reset so a cut-off merge never writes
    assign ram_en    = rst && ((state == IDLE && init_we) || state == ACCESS || state == MERGE);
    assign ram_addr  = (state == IDLE) ? init_addr : addr_q[ADDR_WIDTH+1:2];
    assign ram_we    = (state == IDLE || state == MERGE || (state == ACCESS && write_q && !byte_q)) ? 4'hF : 4'h0;
    assign ram_wdata = (state == IDLE) ? init_data :
                       (state == MERGE) ? lane_merge(ram_rdata, addr_q[1:0], wdata_q[7:0]) : wdata_q;

    assign resp_data = byte_q ? lane_extract(ram_rdata, addr_q[1:0]) : ram_rdata;
    assign cpu_rdata = (state == RESP && !write_q) ? resp_data : rdata_q;
    assign cpu_ready = (state == RESP) || (state == ERR);
    assign cpu_error = (state == ERR);

    sram_1rw #(.ADDR_WIDTH(ADDR_WIDTH)) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_mem_bridge.sv
// tb_mem_bridge: directed checks of the memory bridge at 1, 0 and 5 wait states
module tb_mem_bridge;
    import mem_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] addr [3], wdata [3], rdata [3], idata [3];
    logic        rd [3], wr [3], by [3], iwe [3], rdy [3], err [3];
    logic [9:0]  iaddr [3];
    int          checks = 0;
    int          errors = 0;
    int          lat;
    logic [31:0] q;
    logic        e;

    initial forever #5 clk = ~clk;

    mem_bridge #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u0 (
        .clk(clk), .rst(rst), .cpu_addr(addr[0]), .cpu_wdata(wdata[0]), .cpu_read(rd[0]),
        .cpu_write(wr[0]), .cpu_byte(by[0]), .cpu_rdata(rdata[0]), .cpu_ready(rdy[0]),
        .cpu_error(err[0]), .init_we(iwe[0]), .init_addr(iaddr[0]), .init_data(idata[0]));
    mem_bridge #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u1 (
        .clk(clk), .rst(rst), .cpu_addr(addr[1]), .cpu_wdata(wdata[1]), .cpu_read(rd[1]),
        .cpu_write(wr[1]), .cpu_byte(by[1]), .cpu_rdata(rdata[1]), .cpu_ready(rdy[1]),
        .cpu_error(err[1]), .init_we(iwe[1]), .init_addr(iaddr[1]), .init_data(idata[1]));
    mem_bridge #(.ADDR_WIDTH(10), .WAIT_STATES(5)) u2 (
        .clk(clk), .rst(rst), .cpu_addr(addr[2]), .cpu_wdata(wdata[2]), .cpu_read(rd[2]),
        .cpu_write(wr[2]), .cpu_byte(by[2]), .cpu_rdata(rdata[2]), .cpu_ready(rdy[2]),
        .cpu_error(err[2]), .init_we(iwe[2]), .init_addr(iaddr[2]), .init_data(idata[2]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic init_w(input int i, input logic [9:0] ia, input logic [31:0] id);
        @(negedge clk);
        iwe[i] = 1'b1; iaddr[i] = ia; idata[i] = id;
        @(posedge clk);
        #1 iwe[i] = 1'b0;
    endtask

    // one request; lat = edges from the sampling edge to the edge closing the ready cycle
    task automatic do_req(input int i, input logic r, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d, input logic hold_iwe,
                          output int l, output logic [31:0] qo, output logic eo);
        logic seen;
        seen = 1'b0; l = 0; qo = 32'hx; eo = 1'bx;
        @(negedge clk);
        rd[i] = r; wr[i] = w; by[i] = b; addr[i] = a; wdata[i] = d;
        @(posedge clk);
        #1 rd[i] = 1'b0; wr[i] = 1'b0; iwe[i] = hold_iwe;
        while (!seen && l < 30) begin
            @(negedge clk);
            if (rdy[i]) begin seen = 1'b1; qo = rdata[i]; eo = err[i]; end
            @(posedge clk);
            l++;
        end
        #1 iwe[i] = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL timeout dut%0d observed=no_ready expected=ready", i);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            addr[i] = '0; wdata[i] = '0; idata[i] = '0; iaddr[i] = '0;
            rd[i] = 1'b0; wr[i] = 1'b0; by[i] = 1'b0; iwe[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(rdy[0]), 32'd0);
        check("rst_error", 32'(err[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        rst = 1'b1;

        init_w(0, 10'd0, 32'h11223344);
        do_req(0, 1, 0, 0, 32'h0, 32'h0, 0, lat, q, e);
        check("rd0_data", q, 32'h11223344);
        check("rd0_err", 32'(e), 32'd0);
        check("rd0_lat", 32'(lat), 32'd3);

        do_req(0, 1, 0, 1, 32'h2, 32'h0, 0, lat, q, e);
        check("rdb2_data", q, 32'h00000022);
        check("rdb2_lat", 32'(lat), 32'd3);

        do_req(0, 0, 1, 1, 32'h1, 32'h000000AB, 0, lat, q, e);
        check("wrb1_lat", 32'(lat), 32'd4);
        check("wrb1_err", 32'(e), 32'd0);
        check("wrb1_rdata_held", q, 32'h00000022);
        do_req(0, 1, 0, 0, 32'h0, 32'h0, 0, lat, q, e);
        check("rd0_after_merge", q, 32'h1122AB44);

        do_req(0, 1, 0, 0, 32'h6, 32'h0, 0, lat, q, e);
        check("err_unaligned_flag", 32'(e), 32'd1);
        check("err_unaligned_lat", 32'(lat), 32'd1);
        check("err_unaligned_rdata", q, 32'h1122AB44);
        do_req(0, 1, 0, 0, 32'h1000, 32'h0, 0, lat, q, e);
        check("err_range_flag", 32'(e), 32'd1);
        check("err_range_lat", 32'(lat), 32'd1);
        do_req(0, 1, 1, 0, 32'h0, 32'hFFFFFFFF, 0, lat, q, e);
        check("err_both_flag", 32'(e), 32'd1);
        check("err_both_lat", 32'(lat), 32'd1);

        do_req(0, 0, 1, 0, 32'h4, 32'h01020304, 0, lat, q, e);
        check("wrw4_lat", 32'(lat), 32'd3);
        check("wrw4_err", 32'(e), 32'd0);
        do_req(0, 0, 1, 0, 32'h1004, 32'hBAD0BAD0, 0, lat, q, e);
        check("err_range_wr_flag", 32'(e), 32'd1);
        do_req(0, 1, 0, 0, 32'h4, 32'h0, 0, lat, q, e);
        check("rd4_data", q, 32'h01020304);
        do_req(0, 1, 0, 0, 32'h0, 32'h0, 0, lat, q, e);
        check("rd0_untouched", q, 32'h1122AB44);

        init_w(1, 10'd0, 32'h0BADF00D);
        do_req(1, 1, 0, 0, 32'h0, 32'h0, 0, lat, q, e);
        check("ws0_data", q, 32'h0BADF00D);
        check("ws0_lat", 32'(lat), 32'd2);

        init_w(2, 10'd1, 32'h55AA55AA);
        iaddr[2] = 10'd1; idata[2] = 32'h0;
        do_req(2, 1, 0, 0, 32'h4, 32'h0, 1, lat, q, e);
        check("ws5_data", q, 32'h55AA55AA);
        check("ws5_lat", 32'(lat), 32'd7);
        do_req(2, 1, 0, 0, 32'h4, 32'h0, 0, lat, q, e);
        check("ws5_init_ignored", q, 32'h55AA55AA);

        init_w(0, 10'd3, 32'hDEADBEEF);
        @(negedge clk);
        iwe[0] = 1'b1; iaddr[0] = 10'd3; idata[0] = 32'hCAFEF00D;
        rd[0] = 1'b1; by[0] = 1'b0; addr[0] = 32'hC;
        @(posedge clk);
        #1 iwe[0] = 1'b0;
        do_req(0, 1, 0, 0, 32'hC, 32'h0, 0, lat, q, e);
        check("collision_data", q, 32'hCAFEF00D);
        check("collision_lat", 32'(lat), 32'd3);

        init_w(0, 10'd2, 32'hA1B2C3D4);
        do_req(0, 1, 0, 0, 32'h8, 32'h0, 0, lat, q, e);
        check("rd8_data", q, 32'hA1B2C3D4);
        @(negedge clk);
        wr[0] = 1'b1; by[0] = 1'b1; addr[0] = 32'h9; wdata[0] = 32'h000000EE;
        @(posedge clk);
        #1 wr[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("merge_state", 32'(u0.state), 32'(MERGE));
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_state", 32'(u0.state), 32'(IDLE));
        check("midrst_ready", 32'(rdy[0]), 32'd0);
        check("midrst_error", 32'(err[0]), 32'd0);
        check("midrst_rdata", rdata[0], 32'd0);
        rst = 1'b1;
        do_req(0, 1, 0, 0, 32'h8, 32'h0, 0, lat, q, e);
        check("midrst_word", q, 32'hA1B2C3D4);
        do_req(0, 1, 0, 1, 32'h9, 32'h0, 0, lat, q, e);
        check("midrst_lane1", q, 32'h000000C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
